// File: rtl/mlkem_io_pkg.sv
// Shared types and sizing helpers for the ML-KEM host/core bridge.
// Lane count and counter width derive from the host/core data widths.
package mlkem_io_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } bridge_state_t;

  function automatic int lanes_of(
    input int host_w,
    input int core_w
  );
    return host_w / core_w;
  endfunction

  function automatic int lane_cnt_w(
    input int lanes
  );
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic bit widths_ok(
    input int host_w,
    input int core_w
  );
    return (core_w > 0) && (host_w >= core_w)
      && ((host_w % core_w) == 0);
  endfunction

endpackage

// File: rtl/mlkem_rd_pipe.sv
// Read-latency tag pipe: carries a valid bit and lane index
// alongside the core RAM read so returning data can be steered.
module mlkem_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] vld;
  logic [IDX_W-1:0] idx [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx[k] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      idx[0] <= in_idx;
      for (int k = 1; k < DEPTH; k++) begin
        vld[k] <= vld[k-1];
        idx[k] <= idx[k-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_idx   = idx[DEPTH-1];

endmodule

// File: rtl/mlkem_io_bridge.sv
// Host-to-core bridge: scatters a wide host word into narrow core
// RAM writes and gathers narrow core reads back into a wide word.
module mlkem_io_bridge
  import mlkem_io_pkg::*;
#(
  parameter int HOST_W = 64,
  parameter int CORE_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [HOST_W-1:0] host_wr_data,
  input  logic [ADDR_W-1:0] host_wr_base,
  input  logic              host_rd_req,
  input  logic [ADDR_W-1:0] host_rd_base,
  output logic              host_rd_valid,
  output logic [HOST_W-1:0] host_rd_data,
  output logic              core_we,
  output logic              core_re,
  output logic [ADDR_W-1:0] core_add,
  output logic [CORE_W-1:0] core_din,
  input  logic [CORE_W-1:0] core_dout,
  output logic              busy
);

  localparam int LANES = lanes_of(HOST_W, CORE_W);
  localparam int CNT_W = lane_cnt_w(LANES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  if (!widths_ok(HOST_W, CORE_W)) begin : g_bad_widths
    $error("HOST_W must be a non-zero multiple of CORE_W");
  end

  if (RD_LAT < 1) begin : g_bad_lat
    $error("RD_LAT must be at least 1");
  end

  bridge_state_t     state;
  bridge_state_t     state_nx;
  logic [CNT_W-1:0]  lane;
  logic [ADDR_W-1:0] base;
  logic [HOST_W-1:0] data;
  logic              last_lane;
  logic              wr_go;
  logic              rd_go;
  logic              tag_valid;
  logic [CNT_W-1:0]  tag_idx;

  assign last_lane = (lane == LAST);
  assign wr_go = (state == S_IDLE) && host_wr_valid;
  assign rd_go = (state == S_IDLE) && !host_wr_valid
    && host_rd_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (host_wr_valid) begin
          state_nx = S_WRITE;
        end else if (host_rd_req) begin
          state_nx = S_READ;
        end
      end
      S_WRITE: begin
        if (last_lane) begin
          state_nx = S_IDLE;
        end
      end
      S_READ: begin
        if (last_lane) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // the last issued lane is always the last tag to emerge
        if (tag_valid && (tag_idx == LAST)) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
      base <= '0;
      data <= '0;
    end else if (wr_go) begin
      lane <= '0;
      base <= host_wr_base;
      data <= host_wr_data;
    end else if (rd_go) begin
      lane <= '0;
      base <= host_rd_base;
    end else if ((state == S_WRITE) || (state == S_READ)) begin
      lane <= lane + CNT_W'(1);
    end
  end

  // outputs are forced low while rst is held, whatever the state
  always_comb begin
    host_wr_ready = 1'b0;
    busy          = 1'b0;
    host_rd_valid = 1'b0;
    core_we       = 1'b0;
    core_re       = 1'b0;
    core_add      = '0;
    core_din      = '0;
    if (!rst) begin
      host_wr_ready = (state == S_IDLE);
      busy          = (state != S_IDLE);
      host_rd_valid = (state == S_DONE);
      if (state == S_WRITE) begin
        core_we  = 1'b1;
        core_add = base + ADDR_W'(lane);
        core_din = data[lane*CORE_W +: CORE_W];
      end else if (state == S_READ) begin
        core_re  = 1'b1;
        core_add = base + ADDR_W'(lane);
      end
    end
  end

  mlkem_rd_pipe #(
    .DEPTH (RD_LAT),
    .IDX_W (CNT_W)
  ) u_rd_pipe (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (core_re),
    .in_idx    (lane),
    .out_valid (tag_valid),
    .out_idx   (tag_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      host_rd_data <= '0;
    end else if (tag_valid) begin
      host_rd_data[tag_idx*CORE_W +: CORE_W] <= core_dout;
    end
  end

endmodule

// File: tb/tb_mlkem_io_bridge.sv
// Bench for mlkem_io_bridge: four width/latency configurations, each
// with a core RAM model, directed cases and a cycle-level reference.
module tb_mlkem_io_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(
    input int          cfg,
    input string       name,
    input logic [63:0] got,
    input logic [63:0] want
  );
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL cfg%0d %s: got %h expected %h at %0t",
        cfg, name, got, want, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int HW = (g < 2) ? 64 : 16;
    localparam int CW = 16;
    localparam int RL = ((g % 2) == 0) ? 1 : 3;
    localparam int LN = HW / CW;

    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [HW-1:0] wr_data;
    logic [15:0]   wr_base;
    logic          rd_req;
    logic [15:0]   rd_base;
    logic          rd_valid;
    logic [HW-1:0] rd_data;
    logic          core_we;
    logic          core_re;
    logic [15:0]   core_add;
    logic [CW-1:0] core_din;
    logic [CW-1:0] core_dout;
    logic          busy;
    bit            fin;
    bit            mem_clr;

    mlkem_io_bridge #(
      .HOST_W (HW),
      .CORE_W (CW),
      .ADDR_W (16),
      .RD_LAT (RL)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .host_wr_valid (wr_valid),
      .host_wr_ready (wr_ready),
      .host_wr_data  (wr_data),
      .host_wr_base  (wr_base),
      .host_rd_req   (rd_req),
      .host_rd_base  (rd_base),
      .host_rd_valid (rd_valid),
      .host_rd_data  (rd_data),
      .core_we       (core_we),
      .core_re       (core_re),
      .core_add      (core_add),
      .core_din      (core_din),
      .core_dout     (core_dout),
      .busy          (busy)
    );

    // Core RAM: unwritten words read as addr+0x100; data returns
    // RL cycles after the strobe, random garbage otherwise.
    logic [CW-1:0] mem [65536];
    logic [65535:0] wr_ok;
    logic          pv [RL];
    logic [15:0]   pa [RL];
    logic [CW-1:0] garb;

    always @(posedge clk) begin
      garb  <= CW'($urandom);
      pv[0] <= core_re;
      pa[0] <= core_add;
      for (int k = 1; k < RL; k++) begin
        pv[k] <= pv[k-1];
        pa[k] <= pa[k-1];
      end
      if (mem_clr) begin
        wr_ok <= '0;
      end else if (core_we) begin
        wr_ok[core_add] <= 1'b1;
        mem[core_add]   <= core_din;
      end
    end

    function automatic logic [CW-1:0] rd_val(input logic [15:0] a);
      return wr_ok[a] ? mem[a] : CW'(a + 16'h0100);
    endfunction

    assign core_dout = pv[RL-1] ? rd_val(pa[RL-1]) : garb;

    function automatic logic [HW-1:0] ramp(input logic [15:0] first);
      logic [HW-1:0] w;
      w = '0;
      for (int i = 0; i < LN; i++) begin
        w[i*CW +: CW] = CW'(first + 16'(i));
      end
      return w;
    endfunction

    function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 2))
        0:       return 16'($urandom_range(0, 31));
        1:       return 16'hFFF8 + 16'($urandom_range(0, 7));
        default: return 16'($urandom);
      endcase
    endfunction

    // Reference: one outstanding transaction, timed from its accept
    // cycle; write strobes k=1..LN, read valid at k=LN+RL+1.
    int            cyc;
    int            k;
    int            m_op;
    int            m_t0;
    bit            m_live;
    logic [15:0]   m_base;
    logic [HW-1:0] m_data;
    logic [HW-1:0] m_rdata;

    initial begin : cmp
      bit            e_we;
      bit            e_re;
      bit            e_rv;
      bit            e_rdy;
      logic [15:0]   e_add;
      logic [CW-1:0] e_din;
      cyc = 0; m_live = 0; m_op = 0; m_t0 = 0;
      m_base = '0; m_data = '0; m_rdata = '0;
      forever begin
        @(negedge clk);
        cyc++;
        k = cyc - m_t0;
        e_we  = m_live && !rst && m_op == 1 && k >= 1 && k <= LN;
        e_re  = m_live && !rst && m_op == 2 && k >= 1 && k <= LN;
        e_rv  = m_live && !rst && m_op == 2 && k == LN + RL + 1;
        e_rdy = m_live && !rst && m_op == 0;
        e_add = (e_we || e_re) ? m_base + 16'(k - 1) : 16'h0;
        e_din = e_we ? CW'(m_data >> ((k - 1) * CW)) : '0;
        if (e_rv) begin
          for (int i = 0; i < LN; i++) begin
            m_rdata[i*CW +: CW] = rd_val(m_base + 16'(i));
          end
        end
        if (m_live) begin
          check(g, "m_we",   64'(core_we),  64'(e_we));
          check(g, "m_re",   64'(core_re),  64'(e_re));
          check(g, "m_add",  64'(core_add), 64'(e_add));
          check(g, "m_din",  64'(core_din), 64'(e_din));
          check(g, "m_rv",   64'(rd_valid), 64'(e_rv));
          check(g, "m_rdy",  64'(wr_ready), 64'(e_rdy));
          check(g, "m_busy", 64'(busy),
            64'(m_live && !rst && m_op != 0));
          if (e_rdy || e_rv) begin
            check(g, "m_rdata", 64'(rd_data), 64'(m_rdata));
          end
        end
        if (rst) begin
          m_live  = 1;
          m_op    = 0;
          m_rdata = '0;
        end else if (m_live) begin
          if (m_op == 1 && k == LN) m_op = 0;
          if (m_op == 2 && k == LN + RL + 1) m_op = 0;
          if (e_rdy && wr_valid) begin
            m_op = 1; m_t0 = cyc;
            m_base = wr_base; m_data = wr_data;
          end else if (e_rdy && rd_req) begin
            m_op = 2; m_t0 = cyc;
            m_base = rd_base;
          end
        end
      end
    end

    task automatic dir_read(
      input logic [15:0]   base,
      input logic [HW-1:0] exp,
      input string         tag
    );
      int n;
      @(posedge clk); #1;
      rd_req = 1'b1; rd_base = base;
      @(posedge clk); #1;
      rd_req = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (rd_valid !== 1'b1 && n < LN + RL + 6);
      check(g, {tag, "_lat"},  64'(n),       64'(LN + RL + 1));
      check(g, {tag, "_data"}, 64'(rd_data), 64'(exp));
      @(negedge clk);
      check(g, {tag, "_pulse"}, 64'(rd_valid), 64'd0);
      check(g, {tag, "_rdy"},   64'(wr_ready), 64'd1);
    endtask

    initial begin : stim
      int n;
      logic [15:0] a;
      rst = 1'b1; wr_valid = 1'b0; rd_req = 1'b0;
      wr_data = '0; wr_base = '0; rd_base = '0;
      mem_clr = 1'b1; fin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check(g, "rst_rdy",   64'(wr_ready), 64'd0);
      check(g, "rst_busy",  64'(busy),     64'd0);
      check(g, "rst_rv",    64'(rd_valid), 64'd0);
      check(g, "rst_rdata", 64'(rd_data),  64'd0);
      check(g, "rst_we_re", 64'(core_we | core_re), 64'd0);
      rst = 1'b0; mem_clr = 1'b0;
      @(negedge clk);
      check(g, "rdy_after_rst", 64'(wr_ready), 64'd1);

      @(posedge clk); #1;
      wr_valid = 1'b1; wr_base = 16'h0010;
      wr_data = HW'(64'h0004_0003_0002_0001);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      for (int i = 0; i < LN; i++) begin
        @(negedge clk);
        check(g, "wr10_we",  64'(core_we),  64'd1);
        check(g, "wr10_add", 64'(core_add), 64'(16'h0010 + 16'(i)));
        check(g, "wr10_din", 64'(core_din), 64'(i + 1));
        check(g, "wr10_rdy", 64'(wr_ready), 64'd0);
      end
      @(negedge clk);
      check(g, "wr10_rdy_back", 64'(wr_ready), 64'd1);

      @(posedge clk); #1;
      wr_valid = 1'b1; wr_base = 16'hFFFE;
      wr_data = HW'({$urandom, $urandom});
      @(posedge clk); #1;
      wr_valid = 1'b0;
      for (int i = 0; i < LN; i++) begin
        @(negedge clk);
        a = 16'hFFFE + 16'(i);
        check(g, "wrap_add", 64'(core_add), 64'(a));
      end
      @(negedge clk);
      check(g, "wrap_rdy", 64'(wr_ready), 64'd1);

      dir_read(16'h0020, ramp(16'h0120), "rd20");

      // write and read together: write first, read on ready
      @(posedge clk); #1;
      wr_valid = 1'b1; rd_req = 1'b1;
      wr_base = 16'h0040; rd_base = 16'h0010;
      wr_data = HW'({$urandom, $urandom});
      @(posedge clk); #1;
      wr_valid = 1'b0;
      for (int i = 0; i < LN; i++) begin
        @(negedge clk);
        check(g, "both_we", 64'(core_we), 64'd1);
        check(g, "both_re", 64'(core_re), 64'd0);
      end
      @(negedge clk);
      check(g, "both_rdy", 64'(wr_ready), 64'd1);
      check(g, "both_idle_re", 64'(core_re), 64'd0);
      @(posedge clk); #1;
      rd_req = 1'b0;
      @(negedge clk);
      check(g, "both_rd_re",  64'(core_re),  64'd1);
      check(g, "both_rd_we",  64'(core_we),  64'd0);
      check(g, "both_rd_add", 64'(core_add), 64'h0010);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (rd_valid !== 1'b1 && n < LN + RL + 6);
      check(g, "both_lat",  64'(n),       64'(LN + RL));
      check(g, "both_data", 64'(rd_data), 64'(ramp(16'h0001)));

      // reset during the second cycle of a read
      @(posedge clk); #1;
      rd_req = 1'b1; rd_base = 16'h0020;
      @(posedge clk); #1;
      rd_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < LN + RL + 3; i++) begin
        @(negedge clk);
        check(g, "abort_strobe", 64'(core_we | core_re), 64'd0);
        check(g, "abort_rv",     64'(rd_valid), 64'd0);
        check(g, "abort_rdata",  64'(rd_data),  64'd0);
      end
      check(g, "abort_rdy", 64'(wr_ready), 64'd1);
      dir_read(16'h0030, ramp(16'h0130), "rd_after_rst");

      for (int c = 0; c < 2500; c++) begin
        @(posedge clk); #1;
        rst = ($urandom_range(0, 199) == 0);
        wr_valid = ($urandom_range(0, 3) == 0);
        wr_data = HW'({$urandom, $urandom});
        wr_base = pick_addr();
        if (!rd_req) begin
          rd_req = ($urandom_range(0, 4) == 0);
          rd_base = pick_addr();
        end else if ($urandom_range(0, 7) == 0) begin
          rd_req = 1'b0;
        end
      end
      @(posedge clk); #1;
      rst = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
      repeat (LN + RL + 4) @(posedge clk);
      fin = 1'b1;
    end
  end

  initial begin : top
    int n;
    n = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin
        && g_cfg[3].fin) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      fails++;
      $display("FAIL run_timeout: got %0d cycles, required under 20000",
        n);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule
